// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry fetch FIFO, combinational head decode, registered issue bundle.
// Optional DECODE_QUEUE_BYPASS_EN: an empty queue issues straight from the fetch inputs.
`ifndef DECODE_QUEUE_DEFS
`define DECODE_QUEUE_DEFS
`define INNER_INST_RANGE 5:0
`define NOP   6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif

module decode_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_in,
  input  logic                    fet_valid_in,
  input  logic [WORD_WIDTH-1:0]   fet_inst_in,
  input  logic [WORD_WIDTH-1:0]   fet_pc_in,
  input  logic [WORD_WIDTH-1:0]   fet_predict_pc_in,
  output logic                    fet_ready_out,
  input  logic                    rob_full_in,
  input  logic                    rs_full_in,
  input  logic                    lsb_full_in,
  output logic                    issue_out,
  output logic [`INNER_INST_RANGE] op_out,
  output logic [WORD_WIDTH-1:0]   imm_out,
  output logic [WORD_WIDTH-1:0]   pc_out,
  output logic [WORD_WIDTH-1:0]   predict_pc_out,
  output logic [WORD_WIDTH-1:0]   inst_out,
  output logic [4:0]              rs1_out,
  output logic [4:0]              rs2_out,
  output logic [4:0]              rd_out,
  output logic                    occupy_rd_out,
  output logic                    to_lsb_out,
  output logic                    is_store_out,
  output logic [2:0]              lsb_goal_out,
  output logic [1:0]              src_mask_out,
  output logic [ADDR_WIDTH:0]     count_out
);
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011, OPC_OP = 7'b0110011;

  typedef struct packed {
    logic [`INNER_INST_RANGE] op;
    logic [WORD_WIDTH-1:0]    imm;
    logic [4:0]               rs1, rs2, rd;
    logic                     occupy_rd, to_lsb, is_store;
    logic [2:0]               lsb_goal;
    logic [1:0]               src_mask;
  } dec_t;

  // op == NOP marks an unrecognised encoding
  function automatic dec_t decode(input logic [WORD_WIDTH-1:0] inst);
    dec_t d;
    logic [31:0] imm32;
    logic [2:0]  f3;
    logic        f7z;
    d = '0;
    imm32 = '0;
    f3 = inst[14:12];
    f7z = (inst[31:25] == 7'd0);
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    d.rd  = inst[11:7];
    d.occupy_rd = 1'b1;
    d.src_mask  = 2'b11;
    case (f3[1:0])
      2'b00:   d.lsb_goal = 3'b001;
      2'b01:   d.lsb_goal = 3'b010;
      2'b10:   d.lsb_goal = 3'b100;
      default: d.lsb_goal = 3'b000;
    endcase
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d.op = inst[5] ? `LUI : `AUIPC;
        imm32 = {inst[31:12], 12'b0};
        d.src_mask = 2'b00;
      end
      OPC_JAL: begin
        d.op = `JAL;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d.src_mask = 2'b00;
      end
      OPC_JALR: begin
        d.op = (f3 == 3'd0) ? `JALR : `NOP;
        imm32 = {{20{inst[31]}}, inst[31:20]};
        d.src_mask = 2'b01;
      end
      OPC_BR: begin
        case (f3)
          3'd0: d.op = `BEQ;  3'd1: d.op = `BNE;
          3'd4: d.op = `BLT;  3'd5: d.op = `BGE;
          3'd6: d.op = `BLTU; 3'd7: d.op = `BGEU;
          default: d.op = `NOP;
        endcase
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        d.occupy_rd = 1'b0;
      end
      OPC_LD: begin
        case (f3)
          3'd0: d.op = `LB;  3'd1: d.op = `LH; 3'd2: d.op = `LW;
          3'd4: d.op = `LBU; 3'd5: d.op = `LHU;
          default: d.op = `NOP;
        endcase
        imm32 = {{20{inst[31]}}, inst[31:20]};
        d.src_mask = 2'b01;
        d.to_lsb = 1'b1;
      end
      OPC_ST: begin
        case (f3)
          3'd0: d.op = `SB; 3'd1: d.op = `SH; 3'd2: d.op = `SW;
          default: d.op = `NOP;
        endcase
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d.occupy_rd = 1'b0;
        d.to_lsb = 1'b1;
        d.is_store = 1'b1;
      end
      OPC_OPI: begin
        case (f3)
          3'd0: d.op = `ADDI; 3'd1: d.op = `SLLI; 3'd2: d.op = `SLTI; 3'd3: d.op = `SLTIU;
          3'd4: d.op = `XORI; 3'd5: d.op = f7z ? `SRLI : `SRAI;
          3'd6: d.op = `ORI;  default: d.op = `ANDI;
        endcase
        // shift amounts are zero-expanded, everything else sign-expanded
        imm32 = (f3[1:0] == 2'b01) ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
        d.src_mask = 2'b01;
      end
      OPC_OP: begin
        case (f3)
          3'd0: d.op = f7z ? `ADD : `SUB; 3'd1: d.op = `SLL; 3'd2: d.op = `SLT;
          3'd3: d.op = `SLTU; 3'd4: d.op = `XOR; 3'd5: d.op = f7z ? `SRL : `SRA;
          3'd6: d.op = `OR;   default: d.op = `AND;
        endcase
      end
      default: d.op = `NOP;
    endcase
    if (d.op == `NOP) d.to_lsb = 1'b0;
    d.imm = WORD_WIDTH'($signed(imm32));
    return d;
  endfunction

  logic [WORD_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [WORD_WIDTH-1:0] ppc_mem_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  issue_q, issue_d;
  dec_t                  bund_q, sel_dec, head_dec;
  logic [WORD_WIDTH-1:0] binst_q, bpc_q, bppc_q, sel_inst, sel_pc, sel_ppc;
  logic                  pop, push, bypass;

  assign fet_ready_out = (count_q < (ADDR_WIDTH+1)'(DEPTH));

  always_comb begin
    head_dec = decode(inst_mem_q[head_q]);
    sel_dec  = head_dec;
    sel_inst = inst_mem_q[head_q];
    sel_pc   = pc_mem_q[head_q];
    sel_ppc  = ppc_mem_q[head_q];
    // unknown heads skip the stall check so they can be dropped
    pop = rdy_in && !clear_in && (count_q != '0) &&
          ((head_dec.op == `NOP) ||
           (!rob_full_in && (head_dec.to_lsb ? !lsb_full_in : !rs_full_in)));
    bypass = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
    if (count_q == '0) begin
      sel_dec  = decode(fet_inst_in);
      sel_inst = fet_inst_in;
      sel_pc   = fet_pc_in;
      sel_ppc  = fet_predict_pc_in;
      bypass = rdy_in && !clear_in && fet_valid_in &&
               ((sel_dec.op == `NOP) ||
                (!rob_full_in && (sel_dec.to_lsb ? !lsb_full_in : !rs_full_in)));
    end
`endif
    push    = rdy_in && !clear_in && fet_valid_in && fet_ready_out && !bypass;
    issue_d = (pop || bypass) && (sel_dec.op != `NOP);
    head_d  = head_q + ADDR_WIDTH'(pop);
    tail_d  = tail_q + ADDR_WIDTH'(push);
    count_d = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    if (rdy_in && clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem_q[tail_q] <= fet_inst_in;
      pc_mem_q[tail_q]   <= fet_pc_in;
      ppc_mem_q[tail_q]  <= fet_predict_pc_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      issue_q <= 1'b0;
      bund_q  <= '0;
      binst_q <= '0;
      bpc_q   <= '0;
      bppc_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      issue_q <= issue_d;
      if (issue_d) begin
        bund_q  <= sel_dec;
        binst_q <= sel_inst;
        bpc_q   <= sel_pc;
        bppc_q  <= sel_ppc;
      end
    end
  end

  assign issue_out      = issue_q;
  assign op_out         = bund_q.op;
  assign imm_out        = bund_q.imm;
  assign rs1_out        = bund_q.rs1;
  assign rs2_out        = bund_q.rs2;
  assign rd_out         = bund_q.rd;
  assign occupy_rd_out  = bund_q.occupy_rd;
  assign to_lsb_out     = bund_q.to_lsb;
  assign is_store_out   = bund_q.is_store;
  assign lsb_goal_out   = bund_q.lsb_goal;
  assign src_mask_out   = bund_q.src_mask;
  assign inst_out       = binst_q;
  assign pc_out         = bpc_q;
  assign predict_pc_out = bppc_q;
  assign count_out      = count_q;
endmodule
